// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding and word geometry.
package inst_loader_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned BYTE_W  = INSTR_W / 2;
   localparam int unsigned PC_STEP = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_e;

   // States in which the loader is waiting for a stream byte.
   function automatic logic is_byte_state(state_e s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
             (s == ST_DATA_HI) || (s == ST_DATA_LO);
   endfunction

endpackage

// File: rtl/inst_loader_byte_pair_assembler.sv
// Holds the high byte of a big-endian pair and presents the joined 16-bit word.
module inst_loader_byte_pair_assembler
   import inst_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               hi_load_i,
   input  logic [BYTE_W-1:0]  byte_i,
   output logic [INSTR_W-1:0] word_c
);

   logic [BYTE_W-1:0] hi_q;

   // Capture the high byte when the loader accepts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
      end else if (hi_load_i) begin
         hi_q <= byte_i;
      end
   end

   // The current input byte is the low half of the word.
   assign word_c = {hi_q, byte_i};

endmodule

// File: rtl/inst_loader.sv
// Byte-stream program loader: length header, big-endian words, writes to
// instruction memory at PC-stepped addresses while holding the CPU in reset.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [15:0] words_loaded
);

   localparam int unsigned         TIMER_W    = $clog2(TIMEOUT + 1);
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   state_e               state_q;
   logic [TIMER_W-1:0]   timer_q;
   logic [15:0]          n_q;
   logic [15:0]          idx_q;
   logic                 byte_ready_q;
   logic                 mem_we_q;
   logic [15:0]          mem_addr_q;
   logic [15:0]          mem_wdata_q;
   logic                 cpu_hold_q;
   logic                 done_q;
   logic                 err_q;
   logic [15:0]          words_q;

   logic                 accept_c;
   logic                 hi_load_c;
   logic [INSTR_W-1:0]   word_c;

   assign accept_c  = byte_valid & byte_ready_q;
   assign hi_load_c = accept_c & ((state_q == ST_LEN_HI) | (state_q == ST_DATA_HI));

   inst_loader_byte_pair_assembler u_pair (
      .clk       (clk),
      .reset     (reset),
      .hi_load_i (hi_load_c),
      .byte_i    (byte_in),
      .word_c    (word_c)
   );

   // Loader FSM with registered outputs, byte timeout and word counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         n_q          <= '0;
         idx_q        <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         words_q      <= '0;
      end else begin
         mem_we_q <= 1'b0;
         done_q   <= 1'b0;
         if (is_byte_state(state_q) && !accept_c) begin
            if (timer_q == TIMER_LAST) begin
               state_q      <= ST_ERR;
               err_q        <= 1'b1;
               byte_ready_q <= 1'b0;
               timer_q      <= '0;
            end else begin
               timer_q <= timer_q + TIMER_W'(1);
            end
         end else begin
            timer_q <= '0;
            case (state_q)
               ST_IDLE, ST_ERR: begin
                  if (start) begin
                     state_q      <= ST_LEN_HI;
                     err_q        <= 1'b0;
                     words_q      <= '0;
                     idx_q        <= '0;
                     cpu_hold_q   <= 1'b1;
                     byte_ready_q <= 1'b1;
                  end
               end
               ST_LEN_HI: state_q <= ST_LEN_LO;
               ST_LEN_LO: begin
                  n_q <= word_c;
                  if (word_c == '0) begin
                     state_q      <= ST_DONE;
                     done_q       <= 1'b1;
                     cpu_hold_q   <= 1'b0;
                     byte_ready_q <= 1'b0;
                  end else if (32'(word_c) > DEPTH) begin
                     state_q      <= ST_ERR;
                     err_q        <= 1'b1;
                     byte_ready_q <= 1'b0;
                  end else begin
                     state_q <= ST_DATA_HI;
                  end
               end
               ST_DATA_HI: state_q <= ST_DATA_LO;
               ST_DATA_LO: begin
                  state_q      <= ST_WRITE;
                  mem_we_q     <= 1'b1;
                  mem_addr_q   <= BASE_ADDR + 16'(PC_STEP) * idx_q;
                  mem_wdata_q  <= word_c;
                  words_q      <= idx_q + 16'd1;
                  byte_ready_q <= 1'b0;
               end
               ST_WRITE: begin
                  if (idx_q + 16'd1 == n_q) begin
                     state_q    <= ST_DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     idx_q        <= idx_q + 16'd1;
                     state_q      <= ST_DATA_HI;
                     byte_ready_q <= 1'b1;
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign byte_ready   = byte_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: stream-position reference model compared
// every cycle, plus literal expectations for the directed load scenarios.
module tb_inst_loader;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned TIMEOUT = 8;
   localparam logic [15:0] BASE    = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_in;
   logic        byte_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int n_tests = 0;
   int n_fail  = 0;

   inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .byte_valid   (byte_valid),
      .byte_in      (byte_in),
      .byte_ready   (byte_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (stream position based) ----------------
   localparam int M_IDLE = 0, M_LOAD = 1, M_ERR = 2;
   int          m_mode = M_IDLE;
   int          m_pos = 0, m_n = 0, m_widx = 0, m_idle = 0;
   bit          m_wr_now = 0, m_done_now = 0, m_acc;
   logic [7:0]  m_bytes[$];
   logic        e_ready = 0, e_we = 0, e_hold = 0, e_done = 0, e_err = 0;
   logic [15:0] e_addr = 0, e_wdata = 0, e_words = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mode = M_IDLE; m_pos = 0; m_n = 0; m_widx = 0; m_idle = 0;
         m_wr_now = 0; m_done_now = 0; m_bytes.delete();
         e_ready = 0; e_we = 0; e_hold = 0; e_done = 0; e_err = 0;
         e_addr = 0; e_wdata = 0; e_words = 0;
      end else begin
         m_acc  = byte_valid && e_ready;
         e_we   = 0;
         e_done = 0;
         if (m_wr_now) begin
            m_wr_now = 0;
            if (m_widx == m_n) begin
               e_done = 1; e_hold = 0; e_ready = 0; m_done_now = 1;
            end else begin
               e_ready = 1;
            end
         end else if (m_done_now) begin
            m_done_now = 0;
            m_mode = M_IDLE;
         end else if (m_mode != M_LOAD) begin
            if (start) begin
               m_mode = M_LOAD; m_pos = 0; m_widx = 0; m_idle = 0; m_bytes.delete();
               e_err = 0; e_words = 0; e_hold = 1; e_ready = 1;
            end
         end else if (m_acc) begin
            m_idle = 0;
            m_bytes.push_back(byte_in);
            m_pos++;
            if (m_pos == 2) begin
               m_n = int'(m_bytes[0]) * 256 + int'(m_bytes[1]);
               if (m_n == 0) begin
                  e_done = 1; e_hold = 0; e_ready = 0; m_done_now = 1;
               end else if (m_n > DEPTH) begin
                  m_mode = M_ERR; e_err = 1; e_ready = 0;
               end
            end else if (m_pos > 2 && (m_pos % 2) == 0) begin
               e_we    = 1;
               e_addr  = 16'(int'(BASE) + 2 * m_widx);
               e_wdata = {m_bytes[m_pos-2], m_bytes[m_pos-1]};
               m_widx++;
               e_words = 16'(m_widx);
               e_ready = 0;
               m_wr_now = 1;
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_mode = M_ERR; e_err = 1; e_ready = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare + write capture ----------------
   logic [31:0] wq[$];

   always @(negedge clk) begin
      chk("byte_ready", 32'(byte_ready), 32'(e_ready));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("words_loaded", 32'(words_loaded), 32'(e_words));
      if (e_we) begin
         chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      if (mem_we) wq.push_back({mem_addr, mem_wdata});
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      bit ok = 0;
      if (gap > 0) begin
         byte_valid = 1'b0;
         repeat (gap) tick();
      end
      byte_valid = 1'b1;
      byte_in    = b;
      for (int i = 0; i < 40; i++) begin
         if (byte_ready) begin
            tick();
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) chk("accept_wait", 32'(ok), 32'd1);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         tick();
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   logic [7:0] t5[$];

   initial begin
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      #2;
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // byte_valid in IDLE has no effect
      byte_valid = 1'b1; byte_in = 8'h5A;
      repeat (3) tick();
      byte_valid = 1'b0;

      // 1: N=2, valid held high
      wq.delete();
      do_start();
      chk("t1_hold_after_start", 32'(cpu_hold), 32'd1);
      send(8'h00, 0); send(8'h02, 0);
      send(8'h12, 0); send(8'h34, 0);
      send(8'hAB, 0); send(8'hCD, 0);
      byte_valid = 1'b0;
      wait_done();
      chk("t1_hold_in_done", 32'(cpu_hold), 32'd0);
      chk("t1_words", 32'(words_loaded), 32'd2);
      chk("t1_nwrites", 32'(wq.size()), 32'd2);
      if (wq.size() == 2) begin
         chk("t1_w0", wq[0], 32'h0000_1234);
         chk("t1_w1", wq[1], 32'h0002_ABCD);
      end
      tick();

      // 2: N=0
      wq.delete();
      do_start();
      send(8'h00, 0); send(8'h00, 0);
      byte_valid = 1'b0;
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_err", 32'(err), 32'd0);
      chk("t2_nwrites", 32'(wq.size()), 32'd0);
      tick();

      // 3: oversize N=257
      wq.delete();
      do_start();
      send(8'h01, 0); send(8'h01, 0);
      repeat (3) tick();
      byte_valid = 1'b0;
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_hold", 32'(cpu_hold), 32'd1);
      chk("t3_ready", 32'(byte_ready), 32'd0);
      chk("t3_nwrites", 32'(wq.size()), 32'd0);
      do_start();
      chk("t3_err_cleared", 32'(err), 32'd0);
      chk("t3_reenter_ready", 32'(byte_ready), 32'd1);
      send(8'h00, 0); send(8'h00, 0);
      byte_valid = 1'b0;
      wait_done();
      tick();

      // 4: stall -> timeout after one word
      wq.delete();
      do_start();
      send(8'h00, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
      byte_valid = 1'b0;
      repeat (12) tick();
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_words", 32'(words_loaded), 32'd1);
      chk("t4_ready", 32'(byte_ready), 32'd0);
      chk("t4_nwrites", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) chk("t4_w0", wq[0], 32'h0000_1122);

      // 5: backpressure gaps and ignored mid-load start
      wq.delete();
      t5 = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'hFF, 8'h00};
      do_start();
      for (int i = 0; i < t5.size(); i++) begin
         if (i == 5) begin
            byte_valid = 1'b0;
            do_start();
         end
         send(t5[i], int'($urandom_range(0, 5)));
      end
      byte_valid = 1'b0;
      wait_done();
      chk("t5_words", 32'(words_loaded), 32'd4);
      chk("t5_err", 32'(err), 32'd0);
      chk("t5_nwrites", 32'(wq.size()), 32'd4);
      if (wq.size() == 4) begin
         chk("t5_w0", wq[0], 32'h0000_DEAD);
         chk("t5_w1", wq[1], 32'h0002_BEEF);
         chk("t5_w2", wq[2], 32'h0004_0123);
         chk("t5_w3", wq[3], 32'h0006_FF00);
      end
      tick();

      // 6: reset between HI and LO of word 1
      wq.delete();
      do_start();
      send(8'h00, 0); send(8'h02, 0); send(8'h55, 0); send(8'h66, 0); send(8'h77, 0);
      byte_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("t6_rst_we", 32'(mem_we), 32'd0);
      chk("t6_rst_hold", 32'(cpu_hold), 32'd0);
      chk("t6_rst_ready", 32'(byte_ready), 32'd0);
      chk("t6_rst_words", 32'(words_loaded), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      wq.delete();
      do_start();
      send(8'h00, 0); send(8'h01, 0); send(8'h9A, 0); send(8'hBC, 0);
      byte_valid = 1'b0;
      wait_done();
      chk("t6_words", 32'(words_loaded), 32'd1);
      chk("t6_nwrites", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) chk("t6_w0", wq[0], 32'h0000_9ABC);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Upstream feeder for the instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them into instruction memory at consecutive even byte addresses (PC steps by 2). It holds the CPU core in reset while loading and releases it with a one-cycle done pulse.

Parameters:
DEPTH, 256, instruction memory capacity in 16-bit words; also the maximum legal word count.
BASE_ADDR, 16'h0000, byte address of the first word written; must be even.
TIMEOUT, 1024, maximum idle cycles between accepted bytes during a load before aborting; must be at least 2.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a load.
byte_valid  input  1  byte_in is valid this cycle.
byte_in  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction memory write strobe, one cycle per word.
mem_addr  output  16  byte address of the write.
mem_wdata  output  16  instruction word.
cpu_hold  output  1  holds the CPU/PC in reset while high.
done  output  1  one-cycle pulse on successful completion.
err  output  1  sticky error flag.
words_loaded  output  16  number of words written in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0; internal count, index and timer are 0.
- Stream format: LEN_HI, LEN_LO (word count N), then N words, each as HI byte then LO byte.
- A byte is accepted when byte_valid and byte_ready are both 1 on a rising edge. byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO. byte_ready is a registered function of state and does not depend on byte_valid.
- States and transitions:
  - IDLE: start -> LEN_HI. On this transition err and words_loaded clear and cpu_hold sets.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO on accept:
    - N==0 -> DONE.
    - N>DEPTH -> ERR.
    - Otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO on accept.
  - DATA_LO on accept -> WRITE.
  - WRITE (one cycle):
    - mem_we=1, mem_addr=BASE_ADDR+2*idx (16-bit, wraps modulo 2^16), mem_wdata={hi,lo}.
    - words_loaded=idx+1.
    - Next: idx+1==N -> DONE, else idx++ and -> DATA_HI.
  - DONE (one cycle): done=1, cpu_hold=0, -> IDLE.
  - ERR: err=1 and cpu_hold=1; stays in ERR until start, then -> LEN_HI with err cleared.
- Latency: the write strobe comes exactly one cycle after the LO byte is accepted. The minimum load time is 2+3N cycles from start to the DONE state.
- Timeout:
  - The timer counts cycles in the byte states with no accepted byte and resets on every accept.
  - When the timer reaches TIMEOUT -> ERR.
  - Words already written stay in memory; words_loaded holds that count.
- start is ignored in LEN_*, DATA_*, WRITE and DONE. It is only honoured in IDLE and ERR.
- byte_valid with no byte_ready (IDLE, WRITE, DONE, ERR): the byte is not consumed and there is no side effect.
- A reset assertion mid-load aborts the load immediately. The partial memory contents are left as written; the loader does not erase them.
- cpu_hold is registered: high from the cycle after start is accepted until the DONE cycle, in which it is low.

Decomposition:
- Shared package: the state encoding (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR), the instruction width constant (16) and the PC step constant (2).
- One natural sub-module: byte_pair_assembler. It holds the HI byte register and produces the 16-bit word; the FSM, counters and timer stay in inst_loader.

Test Plan:
1. Load N=2: send 00 02 12 34 AB CD with byte_valid held high -> mem_we pulses at addr 0x0000 data 0x1234, then addr 0x0002 data 0xABCD. Then done=1 for one cycle, cpu_hold falls in the same cycle, words_loaded=2.
2. Load N=0: send 00 00 -> no mem_we, DONE reached right after LEN_LO, done pulses, err=0.
3. Oversize with DEPTH=256: send 01 01 (N=257) -> ERR, err=1, cpu_hold stays 1, no writes. A following start clears err and re-enters LEN_HI.
4. Stall and timeout with TIMEOUT=8: N=3, one word sent, then byte_valid=0 -> after 8 idle cycles the loader enters ERR, words_loaded=1, byte_ready=0.
5. Backpressure and ignored start: byte_valid toggling at random gaps below TIMEOUT, and start asserted mid-load -> the load completes normally, written words are correct, and the start has no effect.
6. Reset mid-load: drive reset low between the HI and LO byte of word 1 -> all outputs go to 0 at once with no mem_we. After reset is released, a fresh start and load runs correctly from idx 0.
